// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: default global-history width,
// the training-queue entry layout and a pointer-width helper.
package bp_pkg;

    // Default global-history width; must match the perceptron's history length.
    localparam int HIST_DEFAULT = 28;

    // One training-queue entry: branch PC, actual outcome and the history
    // that was current before this branch shifted into it.
    typedef struct packed {
        logic [31:0]             pc;
        logic                    taken;
        logic [HIST_DEFAULT-1:0] ghr;
    } btq_entry_t;

    // Width of the packed entry for an arbitrary history length.
    function automatic int entry_width(input int hist);
        return 32 + 1 + hist;
    endfunction

    // Address bits needed to index a power-of-two FIFO of the given depth.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/btq_fifo.sv
// Storage and pointers for the branch training queue. Pointers carry one
// extra wrap bit so full and empty can be told apart when the index bits match.
module btq_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 61
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Full when the index bits agree but the wrap bits differ; empty when all bits agree.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer advance; reset simply empties the queue, stale storage is never read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry write at the tail; storage needs no reset because the pointers gate it.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/branch_train_queue.sv
// Branch training queue: accepts resolved branches from execute, raises a
// one-cycle redirect on a mispredict, keeps the global history and feeds
// training requests to the perceptron in resolution order.
// Optional statistics counters are built when BTQ_STATS_EN is defined.
module branch_train_queue
    import bp_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int HIST         = HIST_DEFAULT,
    parameter int TARGET_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    res_valid,
    output logic                    res_ready,
    input  logic [31:0]             res_pc,
    input  logic                    res_taken,
    input  logic [TARGET_WIDTH-1:0] res_target,
    input  logic                    res_pred_taken,
    input  logic [TARGET_WIDTH-1:0] res_pred_target,
    output logic                    redirect_valid,
    output logic [31:0]             redirect_pc,
    output logic                    train_valid,
    input  logic                    train_ready,
    output logic [31:0]             train_pc,
    output logic                    train_taken,
    output logic [HIST-1:0]         train_ghr,
    output logic [HIST-1:0]         ghr
`ifdef BTQ_STATS_EN
    ,
    output logic [31:0]             stat_resolved,
    output logic [31:0]             stat_mispredict
`endif
);

    localparam int EW = entry_width(HIST);

    logic                       full;
    logic                       empty;
    logic                       push;
    logic                       pop;
    logic                       mispredict;
    logic [EW-1:0]              wr_entry;
    logic [EW-1:0]              rd_entry;
    logic [TARGET_WIDTH+31:0]   target_wide;
    logic [31:0]                target_32;
    logic [31:0]                next_redirect_pc;

    btq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (rd_entry),
        .full    (full),
        .empty   (empty)
    );

    // Handshakes: a full queue refuses a push even if the head leaves this cycle.
    assign res_ready   = !full;
    assign push        = res_valid && res_ready;
    assign train_valid = !empty;
    assign pop         = train_valid && train_ready;

    // Entry captures the history as it was before this branch is shifted in.
    assign wr_entry    = {res_pc, res_taken, ghr};
    assign train_pc    = rd_entry[EW-1 -: 32];
    assign train_taken = rd_entry[HIST];
    assign train_ghr   = rd_entry[HIST-1:0];

    // Target fitted to 32 bits: zero-extends narrow targets, truncates wide ones.
    assign target_wide = {32'd0, res_target};
    assign target_32   = target_wide[31:0];

    // Mispredict and the correct fetch PC for the branch on the input port.
    always_comb begin
        mispredict       = (res_pred_taken != res_taken) ||
                           (res_taken && (res_pred_target != res_target));
        next_redirect_pc = res_taken ? target_32 : (res_pc + 32'd4);
    end

    // History shift and redirect registration; both only move on an accepted push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr            <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= push && mispredict;
            if (push) begin
                ghr         <= {ghr[HIST-2:0], res_taken};
                redirect_pc <= next_redirect_pc;
            end
        end
    end

`ifdef BTQ_STATS_EN
    // Saturating counts of accepted branches and of mispredicted ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_resolved   <= '0;
            stat_mispredict <= '0;
        end else if (push) begin
            if (stat_resolved != '1)                 stat_resolved   <= stat_resolved + 1'b1;
            if (mispredict && stat_mispredict != '1) stat_mispredict <= stat_mispredict + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_train_queue.sv
// Self-checking bench for branch_train_queue: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_branch_train_queue;

    localparam int DEPTH = 4;
    localparam int HIST  = 28;
    localparam int TW    = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            res_valid;
    logic            res_ready;
    logic [31:0]     res_pc;
    logic            res_taken;
    logic [TW-1:0]   res_target;
    logic            res_pred_taken;
    logic [TW-1:0]   res_pred_target;
    logic            redirect_valid;
    logic [31:0]     redirect_pc;
    logic            train_valid;
    logic            train_ready;
    logic [31:0]     train_pc;
    logic            train_taken;
    logic [HIST-1:0] train_ghr;
    logic [HIST-1:0] ghr;
`ifdef BTQ_STATS_EN
    logic [31:0]     stat_resolved;
    logic [31:0]     stat_mispredict;
`endif

    branch_train_queue #(
        .DEPTH        (DEPTH),
        .HIST         (HIST),
        .TARGET_WIDTH (TW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_pc          (res_pc),
        .res_taken       (res_taken),
        .res_target      (res_target),
        .res_pred_taken  (res_pred_taken),
        .res_pred_target (res_pred_target),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .train_valid     (train_valid),
        .train_ready     (train_ready),
        .train_pc        (train_pc),
        .train_taken     (train_taken),
        .train_ghr       (train_ghr),
        .ghr             (ghr)
`ifdef BTQ_STATS_EN
        ,
        .stat_resolved   (stat_resolved),
        .stat_mispredict (stat_mispredict)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: resolved branches waiting for training, in arrival order.
    typedef struct {
        logic [31:0]     pc;
        logic            taken;
        logic [HIST-1:0] hist;
    } ent_t;

    ent_t            q[$];
    logic [HIST-1:0] m_ghr;
    logic            m_rv;
    logic [31:0]     m_rpc;
    int              total;
    int              bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        q.delete();
        m_ghr = '0;
        m_rv  = 1'b0;
        m_rpc = '0;
    endtask

    // Compare every visible output against the model's current state.
    task automatic checkOutput();
        chk("res_ready", res_ready, q.size() < DEPTH);
        chk("train_valid", train_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("train_pc", train_pc, q[0].pc);
            chk("train_taken", train_taken, q[0].taken);
            chk("train_ghr", train_ghr, q[0].hist);
        end
        chk("ghr", ghr, m_ghr);
        chk("redirect_valid", redirect_valid, m_rv);
        if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
    endtask

    // Drive one cycle of inputs, check, clock, then advance the model.
    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic tk,
                                 input logic [31:0] tgt, input logic pt,
                                 input logic [31:0] ptgt, input logic tr);
        logic do_push;
        logic do_pop;
        logic mp;
        ent_t e;
        res_valid       = v;
        res_pc          = pc;
        res_taken       = tk;
        res_target      = tgt;
        res_pred_taken  = pt;
        res_pred_target = ptgt;
        train_ready     = tr;
        #1;
        checkOutput();
        do_push = v && (q.size() < DEPTH);
        do_pop  = tr && (q.size() != 0);
        mp      = (pt != tk) || (tk && (ptgt != tgt));
        @(posedge clk);
        #1;
        if (do_pop) e = q.pop_front();
        if (do_push) begin
            e.pc    = pc;
            e.taken = tk;
            e.hist  = m_ghr;
            q.push_back(e);
            m_ghr = {m_ghr[HIST-2:0], tk};
            m_rpc = tk ? tgt : pc + 32'd4;
        end
        m_rv = do_push && mp;
    endtask

    task automatic idle(input logic tr);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, tr);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (q.size() != 0) idle(1'b1);
        end
        chk("drained", train_valid, 1'b0);
    endtask

    initial begin
        logic [31:0] r_pc;
        logic [31:0] r_tgt;
        logic        r_tk;
        total = 0;
        bad   = 0;
        modelReset();
        rst = 1'b1;
        res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; res_target = '0;
        res_pred_taken = 1'b0; res_pred_target = '0; train_ready = 1'b0;

        // Reset state while reset is held.
        #2;
        chk("rst_res_ready", res_ready, 1'b1);
        chk("rst_train_valid", train_valid, 1'b0);
        chk("rst_ghr", ghr, '0);
        chk("rst_redirect_valid", redirect_valid, 1'b0);
        chk("rst_redirect_pc", redirect_pc, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput();

        // Taken branch predicted not-taken redirects to its target.
        applyStimulus(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
        chk("d1_redirect_valid", redirect_valid, 1'b1);
        chk("d1_redirect_pc", redirect_pc, 32'h200);
        chk("d1_ghr", ghr, 28'h1);
        idle(1'b1);

        // Correctly predicted not-taken branch: no redirect, queued for training.
        applyStimulus(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("d2_redirect_valid", redirect_valid, 1'b0);
        chk("d2_train_pc", train_pc, 32'h104);
        chk("d2_train_taken", train_taken, 1'b0);
        chk("d2_train_ghr", train_ghr, 28'h1);
        drain();

        // Fill the queue, stall a fifth push, then pop one entry.
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1'b1, 32'h200 + 32'(4 * i), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("d3_full_ready", res_ready, 1'b0);
        applyStimulus(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("d3_stalled_ready", res_ready, 1'b0);
        chk("d3_head_kept", train_pc, 32'h200);
        idle(1'b1);
        chk("d3_ready_back", res_ready, 1'b1);
        chk("d3_next_head", train_pc, 32'h204);
        // Refill, then offer a push while popping at full: the push is refused.
        applyStimulus(1'b1, 32'h210, 1'b1, 32'h400, 1'b1, 32'h400, 1'b0);
        applyStimulus(1'b1, 32'h214, 1'b1, 32'h500, 1'b1, 32'h500, 1'b1);
        chk("d3_full_pop_ready", res_ready, 1'b1);
        drain();

        // Direction right but target wrong.
        applyStimulus(1'b1, 32'h500, 1'b1, 32'h340, 1'b1, 32'h300, 1'b0);
        chk("d4_redirect_valid", redirect_valid, 1'b1);
        chk("d4_redirect_pc", redirect_pc, 32'h340);
        drain();

        // Simultaneous push and pop at occupancy 2.
        applyStimulus(1'b1, 32'h600, 1'b1, 32'h700, 1'b1, 32'h700, 1'b0);
        applyStimulus(1'b1, 32'h604, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 32'h608 + 32'(4 * i), i[0], 32'h800, 1'b0, 32'h0, 1'b1);
        chk("d5_occupancy", 32'(q.size()), 32'd2);
        chk("d5_train_valid", train_valid, 1'b1);
        drain();

        // Reset with three entries queued.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 32'h900 + 32'(4 * i), 1'b1, 32'hA00, 1'b1, 32'hA00, 1'b0);
        res_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("d6_train_valid", train_valid, 1'b0);
        chk("d6_ghr", ghr, '0);
        chk("d6_res_ready", res_ready, 1'b1);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle(1'b1);
        chk("d6_no_stale", train_valid, 1'b0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            r_pc  = $urandom & 32'hFFFF_FFFC;
            r_tgt = $urandom;
            r_tk  = 1'($urandom_range(0, 1));
            applyStimulus(1'($urandom_range(0, 9) < 7), r_pc, r_tk, r_tgt,
                          ($urandom_range(0, 3) == 0) ? ~r_tk : r_tk,
                          ($urandom_range(0, 3) == 0) ? $urandom : r_tgt,
                          1'($urandom_range(0, 1)));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
